// File: rtl/banked_memory_if.sv
// Bus bundle for banked_memory: enables, access controls, address/data, read data and active strobe.
interface banked_memory_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              clk_enable;
  logic              lsi_enable;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              active;

  modport master (
    output clk_enable, lsi_enable, we, re, addr, in,
    input  out, active
  );

  modport slave (
    input  clk_enable, lsi_enable, we, re, addr, in,
    output out, active
  );
endinterface

// File: rtl/banked_memory.sv
// Four-bank byte RAM with clock-enable front end; optional low-speed divider built under TAU_LSI_DIV_EN.
module banked_memory #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LSI_DIV = 8
) (
  input logic            clk,
  input logic            reset,
  banked_memory_if.slave bus
);
  localparam int unsigned OFF_W  = ADDR_W - 2;
  localparam int unsigned DEPTH  = 1 << OFF_W;
  localparam int unsigned BANKS  = 4;

  logic [DATA_W-1:0] mem [BANKS][DEPTH];
  logic [1:0]        bank;
  logic [OFF_W-1:0]  off;
  logic              act;
  logic [DATA_W-1:0] out_q;

  assign bank = bus.addr[ADDR_W-1 -: 2];
  assign off  = bus.addr[OFF_W-1:0];

`ifdef TAU_LSI_DIV_EN
  localparam int unsigned DIV_W = (LSI_DIV > 2) ? $clog2(LSI_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_top;

  assign div_top = (div_cnt == DIV_W'(LSI_DIV - 1));

  // Divider runs only in low-speed mode, freezes with clk_enable low.
  always_ff @(posedge clk) begin
    if (reset || !bus.lsi_enable) begin
      div_cnt <= '0;
    end else if (bus.clk_enable) begin
      div_cnt <= div_top ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign act = bus.clk_enable & (~bus.lsi_enable | div_top);
`else
  logic unused_lsi;
  assign unused_lsi = bus.lsi_enable ^ (LSI_DIV == 0);
  assign act        = bus.clk_enable;
`endif

  assign bus.active = act;

  // Array write; a reset cycle drops any pending write.
  always_ff @(posedge clk) begin
    if (!reset && act && bus.we) begin
      mem[bank][off] <= bus.in;
    end
  end

  // Registered read; with we also high this returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (act && bus.re) begin
      out_q <= mem[bank][off];
    end
  end

  assign bus.out = out_q;
endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory: directed plan steps plus random traffic against a flat byte-array model.
module tb_banked_memory;
  logic clk;
  logic reset;

  banked_memory_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  banked_memory #(.ADDR_W(12), .DATA_W(8), .LSI_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef TAU_LSI_DIV_EN
  localparam bit LSI_ON = 1'b1;
`else
  localparam bit LSI_ON = 1'b0;
`endif
  localparam int LSI_DIV = 8;

  logic [7:0] ref_mem [4096];
  bit         known   [4096];
  logic [7:0] exp_out;
  bit         out_known;
  int         checks;
  int         failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of traffic; act is the bench's own prediction of the active strobe.
  task automatic op(input bit ce, input bit lsi, input bit act, input bit w, input bit r,
                    input logic [11:0] a, input logic [7:0] d);
    bus.clk_enable = ce;
    bus.lsi_enable = lsi;
    bus.we         = w;
    bus.re         = r;
    bus.addr       = a;
    bus.in         = d;
    #1;
    chk("active", 8'(bus.active), 8'(act));
    @(posedge clk);
    #1;
    if (act && r) begin
      exp_out   = ref_mem[a];
      out_known = known[a];
    end
    if (act && w) begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
    end
    if (out_known) chk("out", bus.out, exp_out);
  endtask

  task automatic rst_cycle(input bit ce, input bit w, input bit r,
                           input logic [11:0] a, input logic [7:0] d);
    reset          = 1'b1;
    bus.clk_enable = ce;
    bus.lsi_enable = 1'b0;
    bus.we         = w;
    bus.re         = r;
    bus.addr       = a;
    bus.in         = d;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_out   = 8'h00;
    out_known = 1'b1;
    chk("rst_out", bus.out, 8'h00);
  endtask

  initial begin
    int         p;
    bit         a_exp;
    bit         ce;
    logic [11:0] ra;
    checks    = 0;
    failures  = 0;
    out_known = 1'b0;
    exp_out   = 8'h00;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;

    // Reset and enable: dropped writes during reset and while clk_enable is low
    rst_cycle(1'b0, 1'b1, 1'b0, 12'h020, 8'h77);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h020, 8'h5A);
    rst_cycle(1'b1, 1'b1, 1'b0, 12'h020, 8'h77);
    rst_cycle(1'b1, 1'b1, 1'b0, 12'h020, 8'h77);
    op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h020, 8'h99);
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h020, 8'h00);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h020, 8'h00);
    chk("rst_drop", bus.out, 8'h5A);

    // Writes across all banks, then read-back
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 8'hAA);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h001, 8'hBB);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h400, 8'hCC);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h801, 8'hDD);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'hC02, 8'hEE);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 8'h00); chk("rd_000", bus.out, 8'hAA);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 8'h00); chk("rd_001", bus.out, 8'hBB);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h400, 8'h00); chk("rd_400", bus.out, 8'hCC);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h801, 8'h00); chk("rd_801", bus.out, 8'hDD);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'hC02, 8'h00); chk("rd_C02", bus.out, 8'hEE);

    // Bank aliasing: same offset in two banks
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h001, 8'h11);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h401, 8'h22);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 8'h00); chk("alias_001", bus.out, 8'h11);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h401, 8'h00); chk("alias_401", bus.out, 8'h22);

    // Simultaneous we and re returns old data
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h030, 8'h33);
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h030, 8'h44); chk("rw_old", bus.out, 8'h33);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h030, 8'h00); chk("rw_new", bus.out, 8'h44);

    // Low-speed mode: phase p advances once per enabled cycle since lsi_enable rose
    p = 0;
    for (int k = 0; k < LSI_DIV; k++) begin
      a_exp = LSI_ON ? ((p % LSI_DIV) == LSI_DIV - 1) : 1'b1;
      op(1'b1, 1'b1, a_exp, 1'b1, 1'b0, 12'h010, 8'h55);
      p++;
    end
    for (int k = 0; k < 3; k++) op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h010, 8'h00);
    for (int k = 0; k < LSI_DIV; k++) begin
      a_exp = LSI_ON ? ((p % LSI_DIV) == LSI_DIV - 1) : 1'b1;
      op(1'b1, 1'b1, a_exp, 1'b0, 1'b1, 12'h010, 8'h66);
      p++;
    end
    chk("lsi_write", bus.out, 8'h55);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 8'h00);

    // Reset during a read
    rst_cycle(1'b1, 1'b0, 1'b1, 12'h000, 8'h00);
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 8'h00); chk("rst_rd", bus.out, 8'hAA);

    // Random traffic across all banks on a small offset pool
    for (int n = 0; n < 300; n++) begin
      ce = ($urandom_range(0, 3) != 0);
      ra = {2'($urandom_range(0, 3)), 6'h00, 4'($urandom_range(0, 15))};
      op(ce, 1'b0, ce, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/banked_memory.md
# banked_memory

Byte-wide, 4 KiB single-port RAM split into four 1 KiB banks, with an integrated clock-enable and low-speed-divider front end. It replaces the separate clock/memory pair as the storage element of the tau datapath. All accesses are synchronous to one clock. An enable stage decides on which cycles the RAM may act.

## Interface
Parameters:
- ADDR_W, 12: address width; bank select is addr[ADDR_W-1:ADDR_W-2].
- DATA_W, 8: data width.
- LSI_DIV, 8: low-speed divide ratio (≥2). Used only when TAU_LSI_DIV_EN is defined.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- clk_enable, input, 1: master enable; 0 freezes all RAM activity.
- lsi_enable, input, 1: selects low-speed mode (one active cycle per LSI_DIV cycles).
- we, input, 1: write enable.
- re, input, 1: read enable.
- addr, input, 12: byte address. Bits [11:10] select the bank; bits [9:0] give the offset within the bank.
- in, input, 8: write data.
- out, output, 8: registered read data.
- active, output, 1: high during a cycle in which the RAM is allowed to act.

## Operation
- Storage: four banks of 1024×8 each (mem0 to mem3). Bank index is addr[11:10]. Examples: 0x400 maps to mem1[0]; 0xC02 maps to mem3[2].
- Active-cycle condition: active = clk_enable & (!lsi_enable | div_cnt == LSI_DIV-1).
- Write: if active and we, mem[bank][offset] is loaded with `in` at the clock edge.
- Read: if active, re, and not we, `out` is loaded with mem[bank][offset] at the clock edge.
- If we and re are both high, the write takes place and `out` is loaded with the pre-write contents of that location (read-old-data).
- When no read occurs (re=0, !active, or we=1 with re=0), `out` holds its previous value.
- Reset behaviour:
  - `out` is set to 0x00.
  - div_cnt is set to 0.
  - RAM contents are not cleared; a location read before it has ever been written returns an undefined value.
- Reset has priority over any access in the same cycle. A write presented during a reset cycle is dropped.
- Divider counter div_cnt:
  - counts only while clk_enable and lsi_enable are both 1;
  - wraps from LSI_DIV-1 back to 0;
  - is forced to 0 whenever lsi_enable = 0;
  - holds its value while clk_enable = 0.

## Timing
- Write latency: the data is in the array at the edge where active & we is sampled. A read issued on the very next active cycle returns the new data.
- Read latency: one active cycle. `out` becomes valid after the edge at which active & re is sampled.
- In low-speed mode:
  - the first active cycle occurs LSI_DIV cycles after lsi_enable rises (counting from div_cnt = 0);
  - after that, active cycles repeat every LSI_DIV cycles;
  - inputs must be held stable until an active edge has sampled them.
- Deasserting clk_enable in the middle of an operation: the operation does not take effect, `out` holds, and nothing is lost or queued.
- `active` is combinational from clk_enable, lsi_enable and div_cnt.

## Configuration
- TAU_LSI_DIV_EN defined:
  - the divider and the lsi_enable input behave as described above.
- TAU_LSI_DIV_EN not defined:
  - the divider is not built;
  - the lsi_enable input is ignored;
  - active = clk_enable.

## Test plan
- Reset and enable check: hold reset=1 for 2 cycles, then release with clk_enable=0 and we=1 → `out` = 0x00, active = 0, and a following read of that address does not show the write.
- Writes across all banks: with clk_enable=1 and lsi_enable=0, write 0xAA@0x000, 0xBB@0x001, 0xCC@0x400, 0xDD@0x801, 0xEE@0xC02. Then read the five addresses back with re=1 → `out` = AA, BB, CC, DD, EE, each one cycle after its address.
- Bank aliasing check: write 0x11@0x001 and 0x22@0x401 → reading 0x001 returns 0x11 and reading 0x401 returns 0x22.
- Simultaneous we and re: the location holds 0x33; assert we=1, re=1, in=0x44 → `out` = 0x33, and a subsequent read returns 0x44.
- Low-speed mode (macro defined, LSI_DIV=8): assert lsi_enable=1 and hold a write of 0x55@0x010 → active pulses once every 8 cycles, and the write lands only on the first pulse. With the macro undefined, the same stimulus gives active = 1 on every cycle.
- Reset during a read: assert re while 0x000 holds 0xAA, with reset=1 in the same cycle → `out` = 0x00. After reset releases, the read returns 0xAA.
